uart_rx_fifo: RTL

//  Asynchronous serial receiver (8N1, 16x oversampled) with an 8-entry receive FIFO.

---
 rtl/uart_rx_fifo.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver, 16x oversampled, with a small receive FIFO and a
// byte-wide register interface on a shared tristate peripheral bus.
module uart_rx_fifo #(
  parameter int DIVISOR = 27,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  inout  wire  [7:0] D,
  input  logic [1:0] A,
  input  logic       cs,
  input  logic       re,
  input  logic       we,
  output logic       uart_rx_irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(DIVISOR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and oversampling tick
  // ---------------------------------------------------------------------------
  logic             rxd_meta;
  logic             rxd_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIVISOR - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [3:0] phase, phase_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [7:0] shift, shift_nxt;
  logic       push;
  logic       frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push      = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick && !rxd_sync) begin
          state_nxt = S_START;
          phase_nxt = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase == 4'd7) begin
            // Mid start bit: still low means a real frame, high was a glitch.
            if (!rxd_sync) begin
              state_nxt = S_DATA;
              phase_nxt = '0;
              bit_nxt   = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            phase_nxt = phase + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (phase == 4'd15) begin
            shift_nxt = {rxd_sync, shift[7:1]};
            phase_nxt = '0;
            if (bit_idx == 3'd7) begin
              state_nxt = S_STOP;
            end else begin
              bit_nxt = bit_idx + 3'd1;
            end
          end else begin
            phase_nxt = phase + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (phase == 4'd15) begin
            phase_nxt = '0;
            if (rxd_sync) begin
              push      = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              frame_err = 1'b1;
              state_nxt = S_BREAK;
            end
          end else begin
            phase_nxt = phase + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rxd_sync) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_q;
  logic rd_head;
  logic rd_head_q;
  logic wr_status;
  logic wr_ctrl;
  logic unused_bits;

  assign rd_q      = cs & re;
  assign rd_head   = rd_q & (A == 2'b00);
  assign wr_status = cs & we & (A == 2'b01);
  assign wr_ctrl   = cs & we & (A == 2'b10);
  assign unused_bits = ^{D[7:4], D[1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_head_q <= 1'b0;
    end else begin
      rd_head_q <= rd_head;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             overrun_set;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Pop on the falling edge of the head read so D holds for the whole strobe;
  // the pop frees a slot before the push is considered.
  assign do_pop      = rd_head_q & ~rd_head & not_empty;
  assign do_push     = push & (~full | do_pop);
  assign overrun_set = push & full & ~do_pop;

  // NOTE: the storage array has no reset; its contents are only visible
  // through count, which is reset, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flags, control and interrupt
  // ---------------------------------------------------------------------------
  logic framing;
  logic overrun;
  logic err_en;

  // A flag being set by the receiver outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      framing <= 1'b0;
      overrun <= 1'b0;
      err_en  <= 1'b0;
    end else begin
      if (frame_err) begin
        framing <= 1'b1;
      end else if (wr_status && D[3]) begin
        framing <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (wr_status && D[2]) begin
        overrun <= 1'b0;
      end
      if (wr_ctrl) begin
        err_en <= D[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_rx_irq <= 1'b0;
    end else begin
      uart_rx_irq <= not_empty | (err_en & (framing | overrun));
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    unique case (A)
      2'b00:   rd_val = not_empty ? mem[rd_ptr] : 8'h00;
      2'b01:   rd_val = {4'b0000, framing, overrun, full, not_empty};
      2'b10:   rd_val = {7'b0000000, err_en};
      default: rd_val = 8'h00;
    endcase
  end

  assign D = rd_q ? rd_val : 8'bz;

endmodule
